// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader.
// Session framing: a count byte (1..64 words), then 4 bytes per word sent
// little-endian, then one checksum byte that is the XOR of all data bytes.
// Assembled words go out on a registered write port. The CPU is held in
// reset until a session completes with a good checksum.
//
//   state | meaning
//   IDLE  | no session since reset, waiting for start
//   COUNT | waiting for the word-count byte
//   DATA  | collecting data bytes and writing whole words
//   CHECK | waiting for the checksum byte
//   DONE  | last session loaded cleanly; CPU released
//   ERR   | last session aborted (bad count or bad checksum)
module imem_loader #(
  parameter int N      = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N-1:0]      mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  // One extra bit lets the word count and word index hold the full
  // depth (64) without wrapping.
  localparam int         IW      = ADDR_W + 1;
  localparam logic [8:0] MAX_CNT = 9'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [1:0]    lane;
  logic [N-9:0]  word_buf;
  logic [IW-1:0] word_idx;
  logic [IW-1:0] word_cnt;
  logic [7:0]    chksum;

  logic beat;
  logic can_start;
  logic cnt_ok;
  logic last_byte;
  logic last_word;

  assign in_ready  = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign beat      = in_valid && in_ready;
  assign can_start = (state == IDLE) || (state == DONE) || (state == ERR);
  assign cnt_ok    = (in_data != 8'd0) && ({1'b0, in_data} <= MAX_CNT);
  assign last_byte = (lane == 2'd3);
  assign last_word = ((word_idx + IW'(1)) == word_cnt);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; start is only honoured outside a session.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nx = COUNT;
      COUNT:           if (beat) state_nx = cnt_ok ? DATA : ERR;
      DATA:            if (beat && last_byte && last_word) state_nx = CHECK;
      CHECK:           if (beat) state_nx = (in_data == chksum) ? DONE : ERR;
      default:         state_nx = IDLE;
    endcase
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      busy     <= (state_nx == COUNT) || (state_nx == DATA) || (state_nx == CHECK);
      done     <= (state_nx == DONE);
      error    <= (state_nx == ERR);
      cpu_hold <= (state_nx != DONE);
    end
  end

  // Byte assembly, checksum and memory write port. Earlier bytes shift
  // down through word_buf so the fourth byte lands on top of the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane      <= 2'd0;
      word_buf  <= '0;
      word_idx  <= '0;
      word_cnt  <= '0;
      chksum    <= 8'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start && can_start) begin
        lane     <= 2'd0;
        word_idx <= '0;
        chksum   <= 8'd0;
      end else if (beat) begin
        case (state)
          COUNT: word_cnt <= in_data[IW-1:0];
          DATA: begin
            chksum <= chksum ^ in_data;
            if (last_byte) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx[ADDR_W-1:0];
              mem_wdata <= {in_data, word_buf};
              word_idx  <= word_idx + IW'(1);
              lane      <= 2'd0;
            end else begin
              word_buf <= {in_data, word_buf[N-9:8]};
              lane     <= lane + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
